game_ctrl: RTL and testbench



---
 rtl/game_pkg.sv | 30 +++
 rtl/game_ctrl_btn_sync.sv | 29 ++
 rtl/game_ctrl.sv | 173 +++++++++++++++++
 tb/tb_game_ctrl.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared definitions for the asteroid game controller and the top-level pixel mux.
package game_pkg;

   // Encodings are visible on the game_state port, so the values are fixed
   typedef enum logic [1:0] {
      ST_TITLE     = 2'b00,
      ST_PLAY      = 2'b01,
      ST_GAME_OVER = 2'b10,
      ST_INVULN    = 2'b11
   } game_state_e;

   localparam int unsigned SCORE_W = 8;
   localparam int unsigned LIVES_W = 2;

   // 12-bit RGB colours used by the pixel mux
   localparam logic [11:0] COL_BLACK = 12'h000;
   localparam logic [11:0] COL_SHIP  = 12'hfff;
   localparam logic [11:0] COL_AST   = 12'h888;
   localparam logic [11:0] COL_TEXT  = 12'hff0;
   localparam logic [11:0] COL_OVER  = 12'hf00;

   // Saturating add for the score; never wraps past all-ones
   function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] a,
                                                  input logic [SCORE_W-1:0] b);
      logic [SCORE_W:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      return sum[SCORE_W] ? {SCORE_W{1'b1}} : sum[SCORE_W-1:0];
   endfunction

endpackage

// File: rtl/game_ctrl_btn_sync.sv
// Two-flop button synchronizer with a pixpulse-qualified rising-edge pulse.
module btn_sync (
   input  logic clk,
   input  logic rst_n,
   input  logic pixpulse,
   input  logic btn,
   output logic level,
   output logic rise
);

   logic meta_q, sync_q, prev_q;

   // Synchronize on every clk; remember the previous level only on pixel enables
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
         prev_q <= 1'b0;
      end else begin
         meta_q <= btn;
         sync_q <= meta_q;
         if (pixpulse) prev_q <= sync_q;
      end
   end

   assign level = sync_q;
   assign rise  = pixpulse & sync_q & ~prev_q;

endmodule

// File: rtl/game_ctrl.sv
// Game-state controller: title/play/invulnerable/game-over, lives and score.
// Optional HIGH_SCORE_EN adds a hi_score output kept across restarts.
module game_ctrl
   import game_pkg::*;
#(
   parameter int unsigned NUM_AST        = 3,
   parameter int unsigned START_LIVES    = 3,
   parameter int unsigned INVULN_FRAMES  = 90,
   parameter int unsigned RESTART_FRAMES = 60,
   parameter int unsigned BLINK_SHIFT    = 3
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               pixpulse,
   input  logic               move,
   input  logic               btn_up,
   input  logic               btn_down,
   input  logic               btn_left,
   input  logic               btn_right,
   input  logic [NUM_AST-1:0] hit,
   input  logic [NUM_AST-1:0] score_inc,
   output logic [1:0]         game_state,
   output logic [LIVES_W-1:0] lives,
   output logic [SCORE_W-1:0] score,
   output logic               play_en,
   output logic               ship_visible,
   output logic               game_over_pulse
`ifdef HIGH_SCORE_EN
   ,
   output logic [SCORE_W-1:0] hi_score
`endif
);

   localparam int unsigned CNT_MAX = (INVULN_FRAMES > RESTART_FRAMES) ? INVULN_FRAMES
                                                                       : RESTART_FRAMES;
   // Wide enough for both frame limits and for the blink bit
   localparam int unsigned CNT_W = ($clog2(CNT_MAX) > BLINK_SHIFT) ? $clog2(CNT_MAX)
                                                                    : BLINK_SHIFT + 1;

   logic [3:0] btn_raw, btn_level, btn_rise;
   logic       any_rise, all_held;

   assign btn_raw = {btn_up, btn_down, btn_left, btn_right};

   for (genvar i = 0; i < 4; i++) begin : g_btn
      btn_sync u_btn_sync (
         .clk      (clk),
         .rst_n    (rst_n),
         .pixpulse (pixpulse),
         .btn      (btn_raw[i]),
         .level    (btn_level[i]),
         .rise     (btn_rise[i])
      );
   end

   assign any_rise = |btn_rise;
   assign all_held = &btn_level;

   game_state_e        state_q, state_d;
   logic [LIVES_W-1:0] lives_q, lives_d;
   logic [SCORE_W-1:0] score_q, score_d, inc_cnt;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               play_en_q, play_en_d, vis_q, vis_d, gop_q, gop_d;

   // Number of asteroids scored this pixel slot
   always_comb begin
      inc_cnt = '0;
      for (int i = 0; i < NUM_AST; i++) begin
         inc_cnt = inc_cnt + {{(SCORE_W-1){1'b0}}, score_inc[i]};
      end
   end

   // Next-state, lives, score and frame/hold counter
   always_comb begin
      state_d = state_q;
      lives_d = lives_q;
      score_d = score_q;
      cnt_d   = cnt_q;
      gop_d   = 1'b0;
      if (state_q == ST_PLAY || state_q == ST_INVULN) begin
         score_d = sat_add(score_q, inc_cnt);
      end
      unique case (state_q)
         ST_TITLE: begin
            if (any_rise) state_d = ST_PLAY;
         end
         ST_PLAY: begin
            // Any number of simultaneous hits costs a single life
            if (|hit && lives_q != '0) begin
               lives_d = lives_q - 1'b1;
               cnt_d   = '0;
               if (lives_d == '0) begin
                  state_d = ST_GAME_OVER;
                  gop_d   = 1'b1;
               end else begin
                  state_d = ST_INVULN;
               end
            end
         end
         ST_INVULN: begin
            if (move) begin
               if (cnt_q == CNT_W'(INVULN_FRAMES - 1)) begin
                  state_d = ST_PLAY;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         ST_GAME_OVER: begin
            if (!all_held) begin
               cnt_d = '0;
            end else if (move) begin
               if (cnt_q == CNT_W'(RESTART_FRAMES - 1)) begin
                  state_d = ST_TITLE;
                  lives_d = LIVES_W'(START_LIVES);
                  score_d = '0;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         default: ;
      endcase
      play_en_d = (state_d == ST_PLAY) || (state_d == ST_INVULN);
      vis_d     = (state_d == ST_INVULN) ? ~cnt_d[BLINK_SHIFT] : 1'b1;
   end

   // All state and registered outputs advance only on pixel enables
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_TITLE;
         lives_q   <= LIVES_W'(START_LIVES);
         score_q   <= '0;
         cnt_q     <= '0;
         play_en_q <= 1'b0;
         vis_q     <= 1'b1;
         gop_q     <= 1'b0;
      end else if (pixpulse) begin
         state_q   <= state_d;
         lives_q   <= lives_d;
         score_q   <= score_d;
         cnt_q     <= cnt_d;
         play_en_q <= play_en_d;
         vis_q     <= vis_d;
         gop_q     <= gop_d;
      end
   end

`ifdef HIGH_SCORE_EN
   logic [SCORE_W-1:0] hi_q;

   // Capture the final score of each game, keeping the best
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hi_q <= '0;
      end else if (pixpulse && gop_d && score_d > hi_q) begin
         hi_q <= score_d;
      end
   end

   assign hi_score = hi_q;
`endif

   assign game_state      = state_q;
   assign lives           = lives_q;
   assign score           = score_q;
   assign play_en         = play_en_q;
   assign ship_visible    = vis_q;
   assign game_over_pulse = gop_q;

endmodule

// File: tb/tb_game_ctrl.sv
// Self-checking bench for game_ctrl: vector table plus hand-written game sequences.
module tb_game_ctrl;
   import game_pkg::*;

   logic       clk = 1'b0, rst_n = 1'b0, pixpulse = 1'b0, move = 1'b0;
   logic       btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
   logic [2:0] hit = '0, score_inc = '0;
   logic [1:0] game_state, lives;
   logic [7:0] score;
   logic       play_en, ship_visible, game_over_pulse;
`ifdef HIGH_SCORE_EN
   logic [7:0] hi_score;
`endif

   game_ctrl dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .pixpulse        (pixpulse),
      .move            (move),
      .btn_up          (btn_up),
      .btn_down        (btn_down),
      .btn_left        (btn_left),
      .btn_right       (btn_right),
      .hit             (hit),
      .score_inc       (score_inc),
      .game_state      (game_state),
      .lives           (lives),
      .score           (score),
      .play_en         (play_en),
      .ship_visible    (ship_visible),
      .game_over_pulse (game_over_pulse)
`ifdef HIGH_SCORE_EN
      ,
      .hi_score        (hi_score)
`endif
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [1:0] st;
      logic [1:0] lv;
      logic [7:0] sc;
      logic       pe;
      logic       vis;
      logic       gop;
   } exp_t;

   typedef struct {
      logic [3:0] btn;   // {up, down, left, right}
      logic       mv;
      logic [2:0] hit;
      logic [2:0] inc;
      exp_t       x;
   } vec_t;

   exp_t sb[$];
   int   vectors = 0;
   int   miscompares = 0;
   vec_t tbl[9];

   function automatic exp_t e(input logic [1:0] st, input logic [1:0] lv, input int sc,
                              input logic pe, input logic vis, input logic gop);
      exp_t r;
      r.st = st; r.lv = lv; r.sc = sc[7:0]; r.pe = pe; r.vis = vis; r.gop = gop;
      return r;
   endfunction

   function automatic vec_t mk(input logic [3:0] b, input logic mv, input logic [2:0] h,
                               input logic [2:0] inc, input exp_t x);
      vec_t v;
      v.btn = b; v.mv = mv; v.hit = h; v.inc = inc; v.x = x;
      return v;
   endfunction

   // One pixel slot: pixpulse for one clk, then three idle clks, outputs settled
   task automatic drive(input logic [3:0] b, input logic mv, input logic [2:0] h,
                        input logic [2:0] inc);
      {btn_up, btn_down, btn_left, btn_right} = b;
      move = mv; hit = h; score_inc = inc; pixpulse = 1'b1;
      @(posedge clk); #1;
      pixpulse = 1'b0; move = 1'b0; hit = '0; score_inc = '0;
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic check(input string name);
      exp_t x, a;
      vectors++;
      if (sb.size() == 0) begin
         miscompares++;
         $display("FAIL %s: scoreboard empty", name);
         return;
      end
      x = sb.pop_front();
      a = {game_state, lives, score, play_en, ship_visible, game_over_pulse};
      if (a !== x) begin
         miscompares++;
         $display("FAIL %s: got st=%b lv=%0d sc=%0d pe=%b vis=%b gop=%b, want st=%b lv=%0d sc=%0d pe=%b vis=%b gop=%b",
                  name, a.st, a.lv, a.sc, a.pe, a.vis, a.gop,
                  x.st, x.lv, x.sc, x.pe, x.vis, x.gop);
      end
   endtask

   task automatic apply(input vec_t v, input string name);
      sb.push_back(v.x);
      drive(v.btn, v.mv, v.hit, v.inc);
      check(name);
   endtask

   task automatic step(input logic [3:0] b, input logic mv, input logic [2:0] h,
                       input logic [2:0] inc, input exp_t x, input string name);
      apply(mk(b, mv, h, inc, x), name);
   endtask

`ifdef HIGH_SCORE_EN
   task automatic check_hi(input logic [7:0] want, input string name);
      vectors++;
      if (hi_score !== want) begin
         miscompares++;
         $display("FAIL %s: hi_score got %0d want %0d", name, hi_score, want);
      end
   endtask
`endif

   initial begin
      // Short opening game: title -> play, scoring, first hit, hits ignored while invulnerable
      tbl[0] = mk(4'b0010, 1'b0, 3'b000, 3'b000, e(2'b00, 3, 0, 0, 1, 0));
      tbl[1] = mk(4'b0010, 1'b0, 3'b000, 3'b000, e(2'b01, 3, 0, 1, 1, 0));
      tbl[2] = mk(4'b0010, 1'b0, 3'b000, 3'b001, e(2'b01, 3, 1, 1, 1, 0));
      tbl[3] = mk(4'b0000, 1'b0, 3'b000, 3'b111, e(2'b01, 3, 4, 1, 1, 0));
      tbl[4] = mk(4'b0001, 1'b0, 3'b000, 3'b010, e(2'b01, 3, 5, 1, 1, 0));
      tbl[5] = mk(4'b0000, 1'b0, 3'b101, 3'b001, e(2'b11, 2, 6, 1, 1, 0));
      tbl[6] = mk(4'b0000, 1'b0, 3'b111, 3'b000, e(2'b11, 2, 6, 1, 1, 0));
      tbl[7] = mk(4'b0000, 1'b1, 3'b000, 3'b000, e(2'b11, 2, 6, 1, 1, 0));
      tbl[8] = mk(4'b0000, 1'b1, 3'b010, 3'b100, e(2'b11, 2, 7, 1, 1, 0));

      repeat (3) @(posedge clk);
      #1;
      sb.push_back(e(2'b00, 3, 0, 0, 1, 0));
      check("reset_values");
      rst_n = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 9; i++) apply(tbl[i], $sformatf("table%0d", i));

      // Rest of the first invulnerable window (frames 3..89), hits ignored, blink every 8
      for (int k = 3; k < 90; k++) begin
         step(4'b0000, 1'b1, (k % 5 == 0) ? 3'b010 : 3'b000, 3'b000,
              e(2'b11, 2, 7, 1, (k % 16) < 8, 0), $sformatf("invuln1_f%0d", k));
      end
      step(4'b0000, 1'b1, 3'b100, 3'b000, e(2'b01, 2, 7, 1, 1, 0), "invuln1_exit");

      step(4'b0000, 1'b0, 3'b001, 3'b000, e(2'b11, 1, 7, 1, 1, 0), "hit2");
      for (int k = 1; k <= 90; k++) begin
         if (k < 90) step(4'b0000, 1'b1, 3'b000, 3'b000,
                          e(2'b11, 1, 7, 1, (k % 16) < 8, 0), $sformatf("invuln2_f%0d", k));
         else        step(4'b0000, 1'b1, 3'b000, 3'b000, e(2'b01, 1, 7, 1, 1, 0), "invuln2_exit");
      end

      // Last life lost with a same-slot score pulse
      step(4'b0000, 1'b0, 3'b001, 3'b001, e(2'b10, 0, 8, 0, 1, 1), "hit3_game_over");
`ifdef HIGH_SCORE_EN
      check_hi(8'd8, "hi_after_game1");
`endif
      step(4'b0000, 1'b0, 3'b000, 3'b111, e(2'b10, 0, 8, 0, 1, 0), "go_pulse_end_score_hold");
      step(4'b0000, 1'b1, 3'b111, 3'b000, e(2'b10, 0, 8, 0, 1, 0), "go_no_underflow");

      // Restart: 59 held frames, release, then a full 60-frame hold
      step(4'b1111, 1'b0, 3'b000, 3'b000, e(2'b10, 0, 8, 0, 1, 0), "hold_sync");
      for (int k = 1; k <= 59; k++)
         step(4'b1111, 1'b1, 3'b000, 3'b000, e(2'b10, 0, 8, 0, 1, 0), $sformatf("hold_a%0d", k));
      step(4'b0111, 1'b0, 3'b000, 3'b000, e(2'b10, 0, 8, 0, 1, 0), "release_up_a");
      step(4'b0111, 1'b0, 3'b000, 3'b000, e(2'b10, 0, 8, 0, 1, 0), "release_up_b");
      step(4'b1111, 1'b0, 3'b000, 3'b000, e(2'b10, 0, 8, 0, 1, 0), "repress");
      for (int k = 1; k <= 60; k++) begin
         if (k < 60) step(4'b1111, 1'b1, 3'b000, 3'b000, e(2'b10, 0, 8, 0, 1, 0),
                          $sformatf("hold_b%0d", k));
         else        step(4'b1111, 1'b1, 3'b000, 3'b000, e(2'b00, 3, 0, 0, 1, 0), "restart");
      end
`ifdef HIGH_SCORE_EN
      check_hi(8'd8, "hi_kept_over_restart");
`endif

      step(4'b0000, 1'b0, 3'b000, 3'b111, e(2'b00, 3, 0, 0, 1, 0), "title_ignores_inc");
      step(4'b0000, 1'b0, 3'b111, 3'b000, e(2'b00, 3, 0, 0, 1, 0), "title_ignores_hit");
      step(4'b1000, 1'b0, 3'b000, 3'b000, e(2'b00, 3, 0, 0, 1, 0), "up_sync_delay");
      step(4'b1000, 1'b0, 3'b000, 3'b000, e(2'b01, 3, 0, 1, 1, 0), "up_starts_game");

      // Inputs with pixpulse low must be ignored
      sb.push_back(e(2'b01, 3, 0, 1, 1, 0));
      score_inc = 3'b111; hit = 3'b111; move = 1'b1;
      repeat (8) @(posedge clk);
      #1;
      score_inc = '0; hit = '0; move = 1'b0;
      check("no_pixpulse_no_update");

      for (int k = 1; k <= 84; k++)
         step(4'b0000, 1'b0, 3'b000, 3'b111, e(2'b01, 3, 3 * k, 1, 1, 0), $sformatf("pump%0d", k));
      step(4'b0000, 1'b0, 3'b000, 3'b011, e(2'b01, 3, 254, 1, 1, 0), "score_254");
      step(4'b0000, 1'b0, 3'b000, 3'b111, e(2'b01, 3, 255, 1, 1, 0), "score_saturate");
      step(4'b0000, 1'b0, 3'b000, 3'b001, e(2'b01, 3, 255, 1, 1, 0), "score_sat_hold");

      // Into a blink-off phase, then asynchronous reset between clock edges
      step(4'b0000, 1'b0, 3'b001, 3'b000, e(2'b11, 2, 255, 1, 1, 0), "hit_game2");
      for (int k = 1; k <= 10; k++)
         step(4'b0000, 1'b1, 3'b000, 3'b000, e(2'b11, 2, 255, 1, (k % 16) < 8, 0),
              $sformatf("invuln3_f%0d", k));
      #2;
      sb.push_back(e(2'b00, 3, 0, 0, 1, 0));
      rst_n = 1'b0;
      #1;
      check("async_reset");
`ifdef HIGH_SCORE_EN
      check_hi(8'd0, "hi_after_reset");
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
